// File: rtl/n64adv2_rst_sequencer.sv
// n64adv2_rst_sequencer: ordered, filtered release of N_CH reset channels with cascaded re-assertion
module n64adv2_rst_sequencer #(
  parameter int N_CH     = 4,
  parameter int BOOT_DLY = 255,
  parameter int REL_DLY  = 15,
  parameter int FILT_LEN = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [N_CH-1:0] ready_i,
  input  logic            ext_nrst_i,
  input  logic [N_CH-1:0] mask_i,
  output logic [N_CH-1:0] ch_nrst_o,
  output logic            boot_done_o,
  output logic            all_up_o
);
  localparam int MAXD = BOOT_DLY > REL_DLY ? BOOT_DLY : REL_DLY;
  localparam int CW = $clog2(MAXD) + 1;
  localparam int FW = $clog2(FILT_LEN) + 1;
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  typedef enum logic [1:0] {BOOT, QUAL, HOLD, UP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [IW-1:0] idx_q, idx_d, dj;
  logic [N_CH-1:0] ready_m, ready_s, cond, ch_d;
  logic ext_m, ext_s, bd_d, au_d, drop;
  assign cond = ready_s & (mask_i | {N_CH{ext_s}});
  // two-stage synchronisers for the asynchronous qualifiers
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      ready_m <= '0;
      ready_s <= '0;
      ext_m   <= 1'b0;
      ext_s   <= 1'b0;
    end else begin
      ready_m <= ready_i;
      ready_s <= ready_m;
      ext_m   <= ext_nrst_i;
      ext_s   <= ext_m;
    end
  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q     <= BOOT;
      cnt_q       <= CW'(BOOT_DLY);
      idx_q       <= '0;
      fcnt_q      <= '0;
      ch_nrst_o   <= '0;
      boot_done_o <= 1'b0;
      all_up_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      ch_nrst_o   <= ch_d;
      boot_done_o <= bd_d;
      all_up_o    <= au_d;
    end
  // lowest released channel that lost its qualification
  always_comb begin
    drop = 1'b0;
    dj = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (ch_nrst_o[i] && !cond[i]) begin
        drop = 1'b1;
        dj = IW'(i);
      end
  end
  // next state: boot countdown, filtered release, hold gap, drop takes priority over release
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    fcnt_d = fcnt_q;
    ch_d = ch_nrst_o;
    bd_d = boot_done_o;
    au_d = all_up_o;
    if (state_q == BOOT) begin
      if (|cnt_q) cnt_d = cnt_q - CW'(1);
      else begin
        state_d = QUAL;
        idx_d = '0;
        fcnt_d = '0;
        bd_d = 1'b1;
      end
    end else if (drop) begin
      ch_d = ch_nrst_o & ~({N_CH{1'b1}} << dj);
      au_d = 1'b0;
      idx_d = dj;
      fcnt_d = '0;
      state_d = QUAL;
    end else if (state_q == QUAL) begin
      if (!cond[idx_q]) fcnt_d = '0;
      else if (fcnt_q < FW'(FILT_LEN - 1)) fcnt_d = fcnt_q + FW'(1);
      else begin
        ch_d = ch_nrst_o | (N_CH'(1) << idx_q);
        if (idx_q == IW'(N_CH - 1)) begin
          state_d = UP;
          au_d = 1'b1;
        end else begin
          state_d = HOLD;
          cnt_d = CW'(REL_DLY);
        end
      end
    end else if (state_q == HOLD) begin
      if (|cnt_q) cnt_d = cnt_q - CW'(1);
      else begin
        idx_d = idx_q + IW'(1);
        fcnt_d = '0;
        state_d = QUAL;
      end
    end
  end
endmodule

// File: tb/tb_n64adv2_rst_sequencer.sv
// tb_n64adv2_rst_sequencer: scoreboard bench with edge-stamped expected output snapshots
module tb_n64adv2_rst_sequencer;
  typedef struct {int e; logic [3:0] ch; logic bd; logic au; string nm;} exp_t;
  logic clk = 0, nrst = 0, ext_nrst_i = 1, boot_done_o, all_up_o;
  logic [3:0] ready_i = '1, mask_i = '0, ch_nrst_o;
  int checks = 0, errors = 0, ec = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  n64adv2_rst_sequencer #(.N_CH(4), .BOOT_DLY(7), .REL_DLY(3), .FILT_LEN(4)) dut (
    .clk(clk), .nrst(nrst), .ready_i(ready_i), .ext_nrst_i(ext_nrst_i),
    .mask_i(mask_i), .ch_nrst_o(ch_nrst_o), .boot_done_o(boot_done_o), .all_up_o(all_up_o));
  task automatic do_reset();
    nrst = 0;
    ready_i = '1;
    ext_nrst_i = 1;
    mask_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1;
    ec = 0;
  endtask
  task automatic test_reset();
    nrst = 0;
    repeat (3) @(posedge clk);
    #1 checks++;
    if ({ch_nrst_o, boot_done_o, all_up_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset: got ch=%b boot=%b up=%b, expected all 0", ch_nrst_o, boot_done_o, all_up_o);
    end
  endtask
  task automatic test_powerup();
    exp_t x;
    do_reset();
    q.push_back('{7, 4'b0000, 1'b0, 1'b0, "boot_pre"});
    q.push_back('{8, 4'b0000, 1'b1, 1'b0, "boot_done"});
    q.push_back('{11, 4'b0000, 1'b1, 1'b0, "ch0_pre"});
    q.push_back('{12, 4'b0001, 1'b1, 1'b0, "ch0_rel"});
    q.push_back('{19, 4'b0001, 1'b1, 1'b0, "ch1_pre"});
    q.push_back('{20, 4'b0011, 1'b1, 1'b0, "ch1_rel"});
    q.push_back('{27, 4'b0011, 1'b1, 1'b0, "ch2_pre"});
    q.push_back('{28, 4'b0111, 1'b1, 1'b0, "ch2_rel"});
    q.push_back('{35, 4'b0111, 1'b1, 1'b0, "ch3_pre"});
    q.push_back('{36, 4'b1111, 1'b1, 1'b1, "all_up"});
    while (q.size() != 0) begin
      @(posedge clk); #1 ec++;
      while (q.size() != 0 && q[0].e <= ec) begin
        x = q.pop_front(); checks++;
        if ({ch_nrst_o, boot_done_o, all_up_o} !== {x.ch, x.bd, x.au}) begin
          errors++;
          $display("FAIL %s edge %0d: got ch=%b boot=%b up=%b, expected ch=%b boot=%b up=%b", x.nm, ec, ch_nrst_o, boot_done_o, all_up_o, x.ch, x.bd, x.au);
        end
      end
    end
  endtask
  task automatic test_filter();
    exp_t x;
    do_reset();
    q.push_back('{12, 4'b0001, 1'b1, 1'b0, "flt_ch0"});
    q.push_back('{30, 4'b0001, 1'b1, 1'b0, "flt_block1"});
    q.push_back('{45, 4'b0001, 1'b1, 1'b0, "flt_block2"});
    q.push_back('{46, 4'b0011, 1'b1, 1'b0, "flt_ch1_rel"});
    q.push_back('{54, 4'b0111, 1'b1, 1'b0, "flt_ch2_rel"});
    q.push_back('{62, 4'b1111, 1'b1, 1'b1, "flt_all_up"});
    while (q.size() != 0) begin
      @(posedge clk); #1 ec++;
      while (q.size() != 0 && q[0].e <= ec) begin
        x = q.pop_front(); checks++;
        if ({ch_nrst_o, boot_done_o, all_up_o} !== {x.ch, x.bd, x.au}) begin
          errors++;
          $display("FAIL %s edge %0d: got ch=%b boot=%b up=%b, expected ch=%b boot=%b up=%b", x.nm, ec, ch_nrst_o, boot_done_o, all_up_o, x.ch, x.bd, x.au);
        end
      end
      if (ec >= 10 && ec < 40) ready_i[1] = (ec % 3 != 0);
      else if (ec == 40) ready_i[1] = 1'b1;
    end
  endtask
  task automatic test_cascade();
    exp_t x;
    int n;
    n = ec + 2;
    q.push_back('{n + 2, 4'b1111, 1'b1, 1'b1, "cas_pre"});
    q.push_back('{n + 3, 4'b0001, 1'b1, 1'b0, "cas_drop"});
    q.push_back('{n + 10, 4'b0001, 1'b1, 1'b0, "cas_ch1_pre"});
    q.push_back('{n + 11, 4'b0011, 1'b1, 1'b0, "cas_ch1_rel"});
    q.push_back('{n + 18, 4'b0011, 1'b1, 1'b0, "cas_ch2_pre"});
    q.push_back('{n + 19, 4'b0111, 1'b1, 1'b0, "cas_ch2_rel"});
    q.push_back('{n + 26, 4'b0111, 1'b1, 1'b0, "cas_ch3_pre"});
    q.push_back('{n + 27, 4'b1111, 1'b1, 1'b1, "cas_all_up"});
    while (q.size() != 0) begin
      @(posedge clk); #1 ec++;
      while (q.size() != 0 && q[0].e <= ec) begin
        x = q.pop_front(); checks++;
        if ({ch_nrst_o, boot_done_o, all_up_o} !== {x.ch, x.bd, x.au}) begin
          errors++;
          $display("FAIL %s edge %0d: got ch=%b boot=%b up=%b, expected ch=%b boot=%b up=%b", x.nm, ec, ch_nrst_o, boot_done_o, all_up_o, x.ch, x.bd, x.au);
        end
      end
      if (ec == n) ready_i[1] = 1'b0;
      if (ec == n + 5) ready_i[1] = 1'b1;
    end
  endtask
  task automatic test_mask();
    exp_t x;
    int n;
    n = ec + 2;
    mask_i = 4'b0101;
    q.push_back('{n + 2, 4'b1111, 1'b1, 1'b1, "msk_pre"});
    q.push_back('{n + 3, 4'b0001, 1'b1, 1'b0, "msk_drop"});
    q.push_back('{n + 20, 4'b0001, 1'b1, 1'b0, "msk_ch0_held"});
    q.push_back('{n + 25, 4'b0001, 1'b1, 1'b0, "msk_ch1_pre"});
    q.push_back('{n + 26, 4'b0011, 1'b1, 1'b0, "msk_ch1_rel"});
    q.push_back('{n + 34, 4'b0111, 1'b1, 1'b0, "msk_ch2_rel"});
    q.push_back('{n + 41, 4'b0111, 1'b1, 1'b0, "msk_ch3_pre"});
    q.push_back('{n + 42, 4'b1111, 1'b1, 1'b1, "msk_all_up"});
    while (q.size() != 0) begin
      @(posedge clk); #1 ec++;
      while (q.size() != 0 && q[0].e <= ec) begin
        x = q.pop_front(); checks++;
        if ({ch_nrst_o, boot_done_o, all_up_o} !== {x.ch, x.bd, x.au}) begin
          errors++;
          $display("FAIL %s edge %0d: got ch=%b boot=%b up=%b, expected ch=%b boot=%b up=%b", x.nm, ec, ch_nrst_o, boot_done_o, all_up_o, x.ch, x.bd, x.au);
        end
      end
      if (ec == n) ext_nrst_i = 1'b0;
      if (ec == n + 20) ext_nrst_i = 1'b1;
    end
    mask_i = '0;
  endtask
  task automatic test_simultaneous();
    exp_t x;
    do_reset();
    q.push_back('{20, 4'b0011, 1'b1, 1'b0, "sim_ch1"});
    q.push_back('{27, 4'b0011, 1'b1, 1'b0, "sim_pre"});
    q.push_back('{28, 4'b0000, 1'b1, 1'b0, "sim_drop_wins"});
    q.push_back('{33, 4'b0000, 1'b1, 1'b0, "sim_ch0_pre"});
    q.push_back('{34, 4'b0001, 1'b1, 1'b0, "sim_ch0_rel"});
    q.push_back('{41, 4'b0001, 1'b1, 1'b0, "sim_ch1_pre"});
    q.push_back('{42, 4'b0011, 1'b1, 1'b0, "sim_ch1_rel"});
    while (q.size() != 0) begin
      @(posedge clk); #1 ec++;
      while (q.size() != 0 && q[0].e <= ec) begin
        x = q.pop_front(); checks++;
        if ({ch_nrst_o, boot_done_o, all_up_o} !== {x.ch, x.bd, x.au}) begin
          errors++;
          $display("FAIL %s edge %0d: got ch=%b boot=%b up=%b, expected ch=%b boot=%b up=%b", x.nm, ec, ch_nrst_o, boot_done_o, all_up_o, x.ch, x.bd, x.au);
        end
      end
      if (ec == 25) ready_i[0] = 1'b0;
      if (ec == 28) ready_i[0] = 1'b1;
    end
  endtask
  task automatic test_nrst_pulse();
    exp_t x;
    do_reset();
    q.push_back('{20, 4'b0011, 1'b1, 1'b0, "rp_ch1"});
    q.push_back('{21, 4'b0011, 1'b1, 1'b0, "rp_hold"});
    while (q.size() != 0) begin
      @(posedge clk); #1 ec++;
      while (q.size() != 0 && q[0].e <= ec) begin
        x = q.pop_front(); checks++;
        if ({ch_nrst_o, boot_done_o, all_up_o} !== {x.ch, x.bd, x.au}) begin
          errors++;
          $display("FAIL %s edge %0d: got ch=%b boot=%b up=%b, expected ch=%b boot=%b up=%b", x.nm, ec, ch_nrst_o, boot_done_o, all_up_o, x.ch, x.bd, x.au);
        end
      end
    end
    nrst = 0;
    #1 checks++;
    if ({ch_nrst_o, boot_done_o, all_up_o} !== 6'b0) begin
      errors++;
      $display("FAIL rp_async: got ch=%b boot=%b up=%b, expected all 0", ch_nrst_o, boot_done_o, all_up_o);
    end
    @(negedge clk) nrst = 1;
    ec = 0;
    q.push_back('{7, 4'b0000, 1'b0, 1'b0, "rp_boot_pre"});
    q.push_back('{8, 4'b0000, 1'b1, 1'b0, "rp_boot_done"});
    q.push_back('{11, 4'b0000, 1'b1, 1'b0, "rp_ch0_pre"});
    q.push_back('{12, 4'b0001, 1'b1, 1'b0, "rp_ch0_rel"});
    while (q.size() != 0) begin
      @(posedge clk); #1 ec++;
      while (q.size() != 0 && q[0].e <= ec) begin
        x = q.pop_front(); checks++;
        if ({ch_nrst_o, boot_done_o, all_up_o} !== {x.ch, x.bd, x.au}) begin
          errors++;
          $display("FAIL %s edge %0d: got ch=%b boot=%b up=%b, expected ch=%b boot=%b up=%b", x.nm, ec, ch_nrst_o, boot_done_o, all_up_o, x.ch, x.bd, x.au);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_powerup();
    test_filter();
    test_cascade();
    test_mask();
    test_simultaneous();
    test_nrst_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
